hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the 3-stage RV32I core: decode/fetch (D), execute (X), writeback/memory-data (W).
- Consumes the decoded register fields (rd, adr1, adr2) and opcode class of the instruction in D, plus redirect and data-memory status.
- Produces stall, flush and operand-forwarding selects.
- Tracks in-flight destinations in an internal two-entry scoreboard (X, W) and freezes the pipe while data memory is busy.

Parameters:
- AW, 5, register address width.
- TIMEOUT, 64, maximum MEM_WAIT cycles before memory error; must be ≥2.
- CNT_W, 32, width of stall performance counter.

Ports:
- clk  in  1  core clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- dec_valid  in  1  D holds a real instruction.
- dec_rd  in  AW  destination of D instruction.
- dec_adr1  in  AW  rs1 of D instruction (0 if unused).
- dec_adr2  in  AW  rs2 of D instruction (0 if unused).
- dec_wr  in  1  D instruction writes rd.
- dec_load  in  1  D instruction is a load.
- dec_mem  in  1  D instruction is a load or store.
- ex_redirect  in  1  X instruction is a taken branch, JAL or JALR; level signal.
- dmem_ready  in  1  data memory has completed the W access.
- stall_f  out  1  hold PC and instruction fetch.
- stall_d  out  1  hold the D register.
- flush_d  out  1  kill the D instruction; do not pass it to X.
- freeze  out  1  hold X and W registers; suppress regfile write.
- fwd_a_sel  out  2  rs1 source entering X: 00 regfile, 01 X result, 10 W data.
- fwd_b_sel  out  2  rs2 source; same encoding.
- mem_err  out  1  one-cycle pulse on memory timeout.
- stall_cnt  out  CNT_W  cycles with stall_f=1 since reset; saturates.

Behaviour:

State:
- Scoreboard entries X and W, each {v, rd, wr, load, mem}.
- FSM states RUN and MEM_WAIT.
- Wait counter wcnt, log2(TIMEOUT)+1 bits.

Reset (async, rst_n=0):
- Scoreboard v=0; FSM=RUN; wcnt=0; stall_cnt=0; mem_err=0.
- All combinational outputs evaluate to 0 / 00 because no entry is valid.

Combinational outputs, in priority order:
1. freeze=1 when (state=MEM_WAIT) or (state=RUN & W.v & W.mem & !dmem_ready). Freeze forces stall_f=stall_d=1, flush_d=0, and no scoreboard update.
2. Redirect: ex_redirect & X.v & !freeze gives flush_d=1, stall_f=0, stall_d=0. Redirect overrides load-use.
3. Load-use: X.v & X.load & X.rd≠0 & dec_valid & (dec_adr1==X.rd | dec_adr2==X.rd) gives stall_f=stall_d=1. X receives a bubble.

Forwarding (per operand):
- 01 if X.v & X.wr & X.rd≠0 & X.rd==adr.
- else 10 if W.v & W.wr & W.rd≠0 & W.rd==adr.
- else 00.
- X has priority over W. rd=0 never forwards.
- During a load-use stall, the select is still computed. After the stall cycle the load sits in W and the select becomes 10.

Sequential updates (when !freeze):
- W ← X.
- X ← D fields with v = dec_valid & !flush_d & !load_use_stall.
- Otherwise v=0 (bubble).

FSM:
- RUN → MEM_WAIT when W.v & W.mem & !dmem_ready; wcnt ← 1.
- MEM_WAIT stays while !dmem_ready and wcnt < TIMEOUT; wcnt increments each cycle.
- MEM_WAIT → RUN on dmem_ready. Pipeline advances normally in that same cycle.
- MEM_WAIT → RUN on wcnt==TIMEOUT & !dmem_ready:
  - mem_err pulses 1 cycle.
  - W.wr forced 0 for that retirement (no writeback or forward).
  - Pipeline advances.
- dmem_ready high in the same cycle as timeout: treated as completion, no error.

Redirect during freeze:
- ex_redirect is ignored while frozen.
- The X instruction is held, so redirect is acted on in the first unfrozen cycle.

stall_cnt:
- Increments on every cycle with stall_f=1.
- Holds at all-ones.

Test Plan:
- add x5 in X, D reads x5 as rs1 and rs2 → fwd_a_sel=fwd_b_sel=01, no stall. Next cycle, with an unrelated D, the x5 producer is in W and a new reader gets 10.
- lw x7 in X, D reads x7 → stall_f=stall_d=1 for exactly 1 cycle; X bubble; following cycle fwd sel=10; stall_cnt=1.
- Taken branch in X (ex_redirect=1) while D reads a loaded register → flush_d=1, stall_d=0, X next cycle v=0, no load-use stall.
- sw in W with dmem_ready low 3 cycles → freeze=1 for 3 cycles; state returns to RUN on ready; scoreboard unchanged during freeze.
- lw in W, dmem_ready never high, TIMEOUT=64 → mem_err pulses on 64th wait cycle; no forward of that rd afterward.
- Writes to x0 in X/W with D reading x0 → fwd sel 00, no stall. rst_n asserted mid-MEM_WAIT → immediate return to RUN, outputs 0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline sequencing controller for the 3-stage RV32I core.
// Stages are D (decode/fetch), X (execute) and W (writeback/memory data).
// A two-entry scoreboard mirrors the destination info of the instructions in
// X (_p1) and W (_p2). The controller produces stall, flush, freeze and the
// operand forwarding selects, and it times out data-memory accesses that
// never complete.
//
// Ports:
//   clk, rst_n                     core clock, async active-low reset
//   dec_valid                      D holds a real instruction
//   dec_rd, dec_adr1, dec_adr2     rd / rs1 / rs2 of the D instruction
//   dec_wr, dec_load, dec_mem      D writes rd / is a load / is a load or store
//   ex_redirect                    X is a taken branch, JAL or JALR
//   dmem_ready                     data memory finished the W access
//   stall_f, stall_d               hold PC+fetch / hold the D register
//   flush_d                        kill the D instruction
//   freeze                         hold X and W, suppress regfile write
//   fwd_a_sel, fwd_b_sel           00 regfile, 01 X result, 10 W data
//   mem_err                        one-cycle pulse on memory timeout
//   stall_cnt                      saturating count of stall_f cycles
module hazard_ctrl #(
  parameter int AW      = 5,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             dec_valid,
  input  logic [AW-1:0]    dec_rd,
  input  logic [AW-1:0]    dec_adr1,
  input  logic [AW-1:0]    dec_adr2,
  input  logic             dec_wr,
  input  logic             dec_load,
  input  logic             dec_mem,
  input  logic             ex_redirect,
  input  logic             dmem_ready,
  output logic             stall_f,
  output logic             stall_d,
  output logic             flush_d,
  output logic             freeze,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int             WCW      = $clog2(TIMEOUT) + 1;
  localparam logic [WCW-1:0] WCNT_MAX = WCW'(TIMEOUT);

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  state_t         state, state_nxt;
  logic [WCW-1:0] wcnt, wcnt_nxt;

  logic           vld_p1;
  logic [AW-1:0]  rd_p1;
  logic           wr_p1;
  logic           load_p1;
  logic           mem_p1;

  logic           vld_p2;
  logic [AW-1:0]  rd_p2;
  logic           wr_p2;
  logic           mem_p2;

  logic           w_busy;
  logic           w_wr_eff;
  logic           redirect;
  logic           load_use;
  logic           lu_stall;
  logic           x_fwd_ok;
  logic           w_fwd_ok;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [1:0] fwd_sel(input logic [AW-1:0] adr,
                                         input logic          x_ok,
                                         input logic [AW-1:0] x_rd,
                                         input logic          w_ok,
                                         input logic [AW-1:0] w_rd);
    if (x_ok && (x_rd == adr)) return 2'b01;
    if (w_ok && (w_rd == adr)) return 2'b10;
    return 2'b00;
  endfunction

  assign w_busy = vld_p2 & mem_p2 & ~dmem_ready;

  // The cycle that leaves MEM_WAIT (completion or timeout) is not frozen,
  // so the pipe advances in that same cycle. On timeout the W entry retires
  // with its write suppressed.
  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    freeze    = 1'b0;
    mem_err   = 1'b0;
    w_wr_eff  = wr_p2;
    case (state)
      RUN: begin
        if (w_busy) begin
          freeze    = 1'b1;
          state_nxt = MEM_WAIT;
          wcnt_nxt  = WCW'(1);
        end
      end
      MEM_WAIT: begin
        if (dmem_ready) begin
          state_nxt = RUN;
          wcnt_nxt  = '0;
        end else if (wcnt >= WCNT_MAX) begin
          state_nxt = RUN;
          wcnt_nxt  = '0;
          mem_err   = 1'b1;
          w_wr_eff  = 1'b0;
        end else begin
          freeze   = 1'b1;
          wcnt_nxt = wcnt + 1'b1;
        end
      end
      default: begin
        state_nxt = RUN;
        wcnt_nxt  = '0;
      end
    endcase
  end

  // Redirect beats load-use; both are ignored while frozen.
  assign redirect = ex_redirect & vld_p1 & ~freeze;
  assign load_use = vld_p1 & load_p1 & (rd_p1 != '0) & dec_valid &
                    ((dec_adr1 == rd_p1) | (dec_adr2 == rd_p1));
  assign lu_stall = load_use & ~freeze & ~redirect;

  assign stall_f = freeze | lu_stall;
  assign stall_d = freeze | lu_stall;
  assign flush_d = redirect;

  assign x_fwd_ok  = vld_p1 & wr_p1 & (rd_p1 != '0);
  assign w_fwd_ok  = vld_p2 & w_wr_eff & (rd_p2 != '0);
  assign fwd_a_sel = fwd_sel(dec_adr1, x_fwd_ok, rd_p1, w_fwd_ok, rd_p2);
  assign fwd_b_sel = fwd_sel(dec_adr2, x_fwd_ok, rd_p1, w_fwd_ok, rd_p2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      wcnt      <= '0;
      vld_p1    <= 1'b0;
      vld_p2    <= 1'b0;
      stall_cnt <= '0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
      if (!freeze) begin
        // D -> X boundary
        vld_p1 <= dec_valid & ~redirect & ~lu_stall;
        // X -> W boundary
        vld_p2 <= vld_p1;
      end
      if (stall_f) begin
        stall_cnt <= sat_inc(stall_cnt);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!freeze) begin
      // D -> X boundary
      rd_p1   <= dec_rd;
      wr_p1   <= dec_wr;
      load_p1 <= dec_load;
      mem_p1  <= dec_mem;
      // X -> W boundary
      rd_p2   <= rd_p1;
      wr_p2   <= wr_p1;
      mem_p2  <= mem_p1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  localparam int TMO = 64;
  localparam longint unsigned CNT_MAX = 64'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        dec_valid = 1'b0;
  logic [4:0]  dec_rd = '0, dec_adr1 = '0, dec_adr2 = '0;
  logic        dec_wr = 1'b0, dec_load = 1'b0, dec_mem = 1'b0;
  logic        ex_redirect = 1'b0;
  logic        dmem_ready = 1'b1;
  logic        stall_f, stall_d, flush_d, freeze, mem_err;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
  logic [31:0] stall_cnt;

  int n_checks = 0;
  int n_fail = 0;

  hazard_ctrl #(.AW(5), .TIMEOUT(TMO), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .dec_valid(dec_valid), .dec_rd(dec_rd),
    .dec_adr1(dec_adr1), .dec_adr2(dec_adr2), .dec_wr(dec_wr),
    .dec_load(dec_load), .dec_mem(dec_mem), .ex_redirect(ex_redirect),
    .dmem_ready(dmem_ready), .stall_f(stall_f), .stall_d(stall_d),
    .flush_d(flush_d), .freeze(freeze), .fwd_a_sel(fwd_a_sel),
    .fwd_b_sel(fwd_b_sel), .mem_err(mem_err), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: the instructions sitting in X and W, and how many
  // cycles the memory access in W has already been kept waiting.
  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       wr;
    logic       load;
    logic       mem;
  } ent_t;

  ent_t            m_x, m_w;
  int              m_age;
  longint unsigned m_cnt;
  logic            e_freeze, e_stall, e_flush, e_err, e_lu;
  logic [1:0]      e_fa, e_fb;

  function automatic logic [1:0] ref_fwd(input logic [4:0] a, input logic wwr);
    if (m_x.v && m_x.wr && m_x.rd != 5'd0 && m_x.rd == a) return 2'b01;
    if (m_w.v && wwr && m_w.rd != 5'd0 && m_w.rd == a) return 2'b10;
    return 2'b00;
  endfunction

  task automatic model_reset();
    m_x = '0;
    m_w = '0;
    m_age = 0;
    m_cnt = 0;
  endtask

  task automatic model_eval();
    logic busy, tmo;
    busy = m_w.v && m_w.mem && !dmem_ready;
    tmo = busy && (m_age == TMO);
    e_err = tmo;
    e_freeze = busy && !tmo;
    e_flush = ex_redirect && m_x.v && !e_freeze;
    e_lu = !e_freeze && !e_flush && m_x.v && m_x.load && m_x.rd != 5'd0 && dec_valid &&
           (dec_adr1 == m_x.rd || dec_adr2 == m_x.rd);
    e_stall = e_freeze || e_lu;
    e_fa = ref_fwd(dec_adr1, m_w.wr && !tmo);
    e_fb = ref_fwd(dec_adr2, m_w.wr && !tmo);
  endtask

  task automatic model_commit();
    model_eval();
    if (e_stall && m_cnt != CNT_MAX) m_cnt++;
    if (e_freeze) begin
      m_age++;
    end else begin
      m_w = m_x;
      m_x.v = dec_valid && !e_flush && !e_lu;
      m_x.rd = dec_rd;
      m_x.wr = dec_wr;
      m_x.load = dec_load;
      m_x.mem = dec_mem;
      m_age = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_commit();
    else model_reset();
    @(negedge clk);
  endtask

  task automatic set_d(input logic v, input logic [4:0] rd, input logic [4:0] a1,
                       input logic [4:0] a2, input logic wr, input logic ld, input logic mem);
    dec_valid = v; dec_rd = rd; dec_adr1 = a1; dec_adr2 = a2;
    dec_wr = wr; dec_load = ld; dec_mem = mem;
  endtask

  task automatic drain();
    set_d(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    ex_redirect = 1'b0;
    dmem_ready = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    model_reset();
    set_d(1'b1, 5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1);
    ex_redirect = 1'b1;
    dmem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_checks++; if (freeze !== 1'b0) begin n_fail++; $display("FAIL rst_freeze: got %b want 0", freeze); end
      n_checks++; if (stall_f !== 1'b0 || stall_d !== 1'b0) begin n_fail++; $display("FAIL rst_stall: got %b%b want 00", stall_f, stall_d); end
      n_checks++; if (flush_d !== 1'b0) begin n_fail++; $display("FAIL rst_flush: got %b want 0", flush_d); end
      n_checks++; if (fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b00) begin n_fail++; $display("FAIL rst_fwd: got %b/%b want 00/00", fwd_a_sel, fwd_b_sel); end
      n_checks++; if (mem_err !== 1'b0) begin n_fail++; $display("FAIL rst_memerr: got %b want 0", mem_err); end
      n_checks++; if (stall_cnt !== 32'd0) begin n_fail++; $display("FAIL rst_cnt: got %0d want 0", stall_cnt); end
      tick();
    end
    rst_n = 1'b1;
    drain();
  endtask

  task automatic test_forward();
    set_d(1'b1, 5'd5, 5'd1, 5'd2, 1'b1, 1'b0, 1'b0);
    #1;
    n_checks++; if (fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b00) begin n_fail++; $display("FAIL fwd_empty: got %b/%b want 00/00", fwd_a_sel, fwd_b_sel); end
    tick();
    set_d(1'b1, 5'd9, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0);
    #1;
    n_checks++; if (fwd_a_sel !== 2'b01 || fwd_b_sel !== 2'b01) begin n_fail++; $display("FAIL fwd_x: got %b/%b want 01/01", fwd_a_sel, fwd_b_sel); end
    n_checks++; if (stall_f !== 1'b0) begin n_fail++; $display("FAIL fwd_x_nostall: got %b want 0", stall_f); end
    tick();
    set_d(1'b1, 5'd10, 5'd5, 5'd3, 1'b1, 1'b0, 1'b0);
    #1;
    n_checks++; if (fwd_a_sel !== 2'b10 || fwd_b_sel !== 2'b00) begin n_fail++; $display("FAIL fwd_w: got %b/%b want 10/00", fwd_a_sel, fwd_b_sel); end
    tick();
    drain();
  endtask

  task automatic test_load_use();
    set_d(1'b1, 5'd7, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1);
    tick();
    set_d(1'b1, 5'd7, 5'd7, 5'd0, 1'b1, 1'b0, 1'b0);
    #1;
    n_checks++; if (stall_f !== 1'b1 || stall_d !== 1'b1) begin n_fail++; $display("FAIL lu_stall: got %b%b want 11", stall_f, stall_d); end
    n_checks++; if (flush_d !== 1'b0) begin n_fail++; $display("FAIL lu_flush: got %b want 0", flush_d); end
    n_checks++; if (fwd_a_sel !== 2'b01) begin n_fail++; $display("FAIL lu_fwd_during: got %b want 01", fwd_a_sel); end
    tick();
    #1;
    n_checks++; if (stall_f !== 1'b0 || stall_d !== 1'b0) begin n_fail++; $display("FAIL lu_once: got %b%b want 00", stall_f, stall_d); end
    n_checks++; if (fwd_a_sel !== 2'b10) begin n_fail++; $display("FAIL lu_fwd_after: got %b want 10", fwd_a_sel); end
    n_checks++; if (stall_cnt !== 32'd1) begin n_fail++; $display("FAIL lu_cnt: got %0d want 1", stall_cnt); end
    tick();
    drain();
  endtask

  task automatic test_redirect();
    set_d(1'b1, 5'd4, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1);
    tick();
    set_d(1'b1, 5'd4, 5'd4, 5'd4, 1'b1, 1'b0, 1'b0);
    ex_redirect = 1'b1;
    #1;
    n_checks++; if (flush_d !== 1'b1) begin n_fail++; $display("FAIL redir_flush: got %b want 1", flush_d); end
    n_checks++; if (stall_f !== 1'b0 || stall_d !== 1'b0) begin n_fail++; $display("FAIL redir_nostall: got %b%b want 00", stall_f, stall_d); end
    tick();
    set_d(1'b1, 5'd9, 5'd4, 5'd0, 1'b1, 1'b0, 1'b0);
    #1;
    n_checks++; if (flush_d !== 1'b0) begin n_fail++; $display("FAIL redir_bubble_flush: got %b want 0", flush_d); end
    n_checks++; if (fwd_a_sel !== 2'b10) begin n_fail++; $display("FAIL redir_bubble_fwd: got %b want 10", fwd_a_sel); end
    n_checks++; if (stall_cnt !== 32'd1) begin n_fail++; $display("FAIL redir_cnt: got %0d want 1", stall_cnt); end
    tick();
    drain();
  endtask

  task automatic test_mem_freeze();
    set_d(1'b1, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b1);
    tick();
    set_d(1'b1, 5'd12, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    tick();
    set_d(1'b1, 5'd13, 5'd12, 5'd12, 1'b1, 1'b0, 1'b0);
    dmem_ready = 1'b0;
    ex_redirect = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if (freeze !== 1'b1) begin n_fail++; $display("FAIL frz_freeze[%0d]: got %b want 1", i, freeze); end
      n_checks++; if (stall_f !== 1'b1 || stall_d !== 1'b1 || flush_d !== 1'b0) begin n_fail++; $display("FAIL frz_ctl[%0d]: got sf%b sd%b fl%b want 110", i, stall_f, stall_d, flush_d); end
      n_checks++; if (fwd_a_sel !== 2'b01 || fwd_b_sel !== 2'b01) begin n_fail++; $display("FAIL frz_hold[%0d]: got %b/%b want 01/01", i, fwd_a_sel, fwd_b_sel); end
      tick();
    end
    dmem_ready = 1'b1;
    #1;
    n_checks++; if (freeze !== 1'b0 || stall_f !== 1'b0) begin n_fail++; $display("FAIL frz_release: got frz%b sf%b want 00", freeze, stall_f); end
    n_checks++; if (flush_d !== 1'b1) begin n_fail++; $display("FAIL frz_late_redir: got %b want 1", flush_d); end
    tick();
    ex_redirect = 1'b0;
    #1;
    n_checks++; if (fwd_a_sel !== 2'b10) begin n_fail++; $display("FAIL frz_after_fwd: got %b want 10", fwd_a_sel); end
    n_checks++; if (stall_cnt !== 32'd4) begin n_fail++; $display("FAIL frz_cnt: got %0d want 4", stall_cnt); end
    tick();
    drain();
  endtask

  task automatic test_timeout();
    set_d(1'b1, 5'd7, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1);
    tick();
    set_d(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
    set_d(1'b1, 5'd14, 5'd7, 5'd7, 1'b1, 1'b0, 1'b0);
    dmem_ready = 1'b0;
    for (int k = 0; k < TMO; k++) begin
      #1;
      if (freeze !== 1'b1 || mem_err !== 1'b0 || fwd_a_sel !== 2'b10) begin
        n_fail++;
        $display("FAIL tmo_wait[%0d]: got frz%b err%b fwd%b want frz1 err0 fwd10", k, freeze, mem_err, fwd_a_sel);
      end
      n_checks++;
      tick();
    end
    #1;
    n_checks++; if (mem_err !== 1'b1) begin n_fail++; $display("FAIL tmo_err: got %b want 1", mem_err); end
    n_checks++; if (freeze !== 1'b0 || stall_f !== 1'b0) begin n_fail++; $display("FAIL tmo_advance: got frz%b sf%b want 00", freeze, stall_f); end
    n_checks++; if (fwd_a_sel !== 2'b00) begin n_fail++; $display("FAIL tmo_nofwd: got %b want 00", fwd_a_sel); end
    tick();
    #1;
    n_checks++; if (mem_err !== 1'b0 || freeze !== 1'b0) begin n_fail++; $display("FAIL tmo_pulse: got err%b frz%b want 00", mem_err, freeze); end
    n_checks++; if (fwd_a_sel !== 2'b00) begin n_fail++; $display("FAIL tmo_after_fwd: got %b want 00", fwd_a_sel); end
    n_checks++; if (stall_cnt !== 32'd68) begin n_fail++; $display("FAIL tmo_cnt: got %0d want 68", stall_cnt); end
    tick();
    drain();
  endtask

  task automatic test_x0_and_async_reset();
    set_d(1'b1, 5'd0, 5'd1, 5'd1, 1'b1, 1'b1, 1'b1);
    tick();
    set_d(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    #1;
    n_checks++; if (stall_f !== 1'b0) begin n_fail++; $display("FAIL x0_nostall: got %b want 0", stall_f); end
    n_checks++; if (fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b00) begin n_fail++; $display("FAIL x0_fwd_x: got %b/%b want 00/00", fwd_a_sel, fwd_b_sel); end
    tick();
    set_d(1'b1, 5'd3, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    #1;
    n_checks++; if (fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b00) begin n_fail++; $display("FAIL x0_fwd_w: got %b/%b want 00/00", fwd_a_sel, fwd_b_sel); end
    tick();
    set_d(1'b1, 5'd5, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1);
    tick();
    set_d(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
    set_d(1'b1, 5'd6, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0);
    dmem_ready = 1'b0;
    tick();
    #1;
    n_checks++; if (freeze !== 1'b1) begin n_fail++; $display("FAIL arst_pre: got %b want 1", freeze); end
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++; if (freeze !== 1'b0 || stall_f !== 1'b0 || stall_d !== 1'b0 || flush_d !== 1'b0) begin n_fail++; $display("FAIL arst_ctl: got frz%b sf%b sd%b fl%b want 0000", freeze, stall_f, stall_d, flush_d); end
    n_checks++; if (fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b00 || mem_err !== 1'b0) begin n_fail++; $display("FAIL arst_fwd: got %b/%b err%b want 00/00 err0", fwd_a_sel, fwd_b_sel, mem_err); end
    n_checks++; if (stall_cnt !== 32'd0) begin n_fail++; $display("FAIL arst_cnt: got %0d want 0", stall_cnt); end
    tick();
    rst_n = 1'b1;
    drain();
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      dec_valid = ($urandom_range(0, 9) < 8);
      dec_rd = 5'($urandom_range(0, 3));
      dec_adr1 = 5'($urandom_range(0, 3));
      dec_adr2 = 5'($urandom_range(0, 3));
      dec_wr = ($urandom_range(0, 3) != 0);
      dec_load = ($urandom_range(0, 2) == 0);
      dec_mem = dec_load | ($urandom_range(0, 3) == 0);
      ex_redirect = ($urandom_range(0, 6) == 0);
      dmem_ready = ($urandom_range(0, 4) != 0);
      if ((i % 500) >= 400 && (i % 500) < 480) dmem_ready = 1'b0;
      #1;
      model_eval();
      n_checks++; if (freeze !== e_freeze) begin n_fail++; $display("FAIL rnd_freeze[%0d]: got %b want %b", i, freeze, e_freeze); end
      n_checks++; if (stall_f !== e_stall) begin n_fail++; $display("FAIL rnd_stall_f[%0d]: got %b want %b", i, stall_f, e_stall); end
      n_checks++; if (stall_d !== e_stall) begin n_fail++; $display("FAIL rnd_stall_d[%0d]: got %b want %b", i, stall_d, e_stall); end
      n_checks++; if (flush_d !== e_flush) begin n_fail++; $display("FAIL rnd_flush[%0d]: got %b want %b", i, flush_d, e_flush); end
      n_checks++; if (fwd_a_sel !== e_fa) begin n_fail++; $display("FAIL rnd_fwd_a[%0d]: got %b want %b", i, fwd_a_sel, e_fa); end
      n_checks++; if (fwd_b_sel !== e_fb) begin n_fail++; $display("FAIL rnd_fwd_b[%0d]: got %b want %b", i, fwd_b_sel, e_fb); end
      n_checks++; if (mem_err !== e_err) begin n_fail++; $display("FAIL rnd_mem_err[%0d]: got %b want %b", i, mem_err, e_err); end
      n_checks++; if (stall_cnt !== 32'(m_cnt)) begin n_fail++; $display("FAIL rnd_cnt[%0d]: got %0d want %0d", i, stall_cnt, m_cnt); end
      tick();
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_forward();
    test_load_use();
    test_redirect();
    test_mem_freeze();
    test_timeout();
    test_x0_and_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
